// File: rtl/motion_segment_queue.sv
// Motion segment command queue: buffers host-pushed segments in a circular FIFO and
// sequences them one at a time onto registered value buses with one-cycle load strobes.
module motion_segment_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_stb,
    input  logic [31:0]   wr_dt,
    input  logic [31:0]   wr_steps,
    input  logic [31:0]   wr_a,
    input  logic [31:0]   wr_j,
    input  logic          start,
    input  logic          stop,
    input  logic          done,
    input  logic          abort,
    output logic [31:0]   dt_val,
    output logic [31:0]   steps_val,
    output logic [31:0]   a_val,
    output logic [31:0]   j_val,
    output logic          load,
    output logic          set_dt_limit,
    output logic          set_steps_limit,
    output logic          set_a,
    output logic          set_j,
    output logic          reset_dt,
    output logic          reset_steps,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          running,
    output logic          busy,
    output logic          underrun,
    output logic          aborted
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [DW-1:0] dt;
        logic [DW-1:0] steps;
        logic [DW-1:0] a;
        logic [DW-1:0] j;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    seg_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nx;
    logic            run_en;
    logic            flush;
    logic            push;
    logic            pop;
    logic            underrun_ev;
    logic            load_nx;
    logic            busy_nx;

    // Running as it will be after this edge; stop beats start, HALT ignores start.
    assign run_en = (running | start) & ~stop & (state != HALT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (run_en && !empty) state_nx = ISSUE;
            ISSUE:   state_nx = RUN;
            RUN:     if (done) state_nx = (run_en && !empty) ? ISSUE : IDLE;
            HALT:    if (stop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = HALT;
    end

    // Datapath controls derived from state and inputs
    always_comb begin
        flush       = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;
        underrun_ev = 1'b0;
        load_nx     = 1'b0;
        busy_nx     = 1'b0;
        count_nx    = count;
        flush       = abort | stop;
        pop         = (state == ISSUE) & ~abort;
        push        = wr_stb & ~full & ~flush;
        underrun_ev = (state == RUN) & done & ~abort & empty & run_en;
        count_nx    = count + CW'(push) - CW'(pop);
        load_nx     = pop;
        busy_nx     = (state_nx == ISSUE) | (state_nx == RUN);
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dt: wr_dt, steps: wr_steps, a: wr_a, j: wr_j};
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nx;
            empty <= (count_nx == '0);
            full  <= (count_nx == CW'(DEPTH));
        end
    end

    // Value buses hold the last issued segment until the next pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dt_val    <= '0;
            steps_val <= '0;
            a_val     <= '0;
            j_val     <= '0;
        end else if (pop) begin
            dt_val    <= mem[rd_ptr].dt;
            steps_val <= mem[rd_ptr].steps;
            a_val     <= mem[rd_ptr].a;
            j_val     <= mem[rd_ptr].j;
        end
    end

    // Status and strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load     <= 1'b0;
            busy     <= 1'b0;
            running  <= 1'b0;
            underrun <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            load <= load_nx;
            busy <= busy_nx;
            if (abort || stop || underrun_ev) begin
                running <= 1'b0;
            end else if (start && state != HALT) begin
                running <= 1'b1;
            end
            if (stop) begin
                underrun <= 1'b0;
            end else if (underrun_ev) begin
                underrun <= 1'b1;
            end
            if (abort) begin
                aborted <= 1'b1;
            end else if (stop) begin
                aborted <= 1'b0;
            end
        end
    end

    assign set_dt_limit    = load;
    assign set_steps_limit = load;
    assign set_a           = load;
    assign set_j           = load;
    assign reset_dt        = load;
    assign reset_steps     = load;

endmodule

// File: tb/tb_motion_segment_queue.sv
// Self-checking bench for motion_segment_queue: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue-based model.
module tb_motion_segment_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    typedef struct packed {
        logic [31:0] dt;
        logic [31:0] steps;
        logic [31:0] a;
        logic [31:0] j;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_stb, start, stop, done, abort;
    logic [31:0] wr_dt, wr_steps, wr_a, wr_j;
    logic [31:0] dt_val, steps_val, a_val, j_val;
    logic        load, set_dt_limit, set_steps_limit, set_a, set_j, reset_dt, reset_steps;
    logic        full, empty, running, busy, underrun, aborted;
    logic [AW:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    motion_segment_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(rst_n),
        .wr_stb(wr_stb), .wr_dt(wr_dt), .wr_steps(wr_steps), .wr_a(wr_a), .wr_j(wr_j),
        .start(start), .stop(stop), .done(done), .abort(abort),
        .dt_val(dt_val), .steps_val(steps_val), .a_val(a_val), .j_val(j_val),
        .load(load), .set_dt_limit(set_dt_limit), .set_steps_limit(set_steps_limit),
        .set_a(set_a), .set_j(set_j), .reset_dt(reset_dt), .reset_steps(reset_steps),
        .full(full), .empty(empty), .count(count),
        .running(running), .busy(busy), .underrun(underrun), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending segments as a queue, execution tracked as
    // "a pop is due at the next edge" and "a segment is out executing".
    seg_t mq[$];
    bit   m_running = 0, m_underrun = 0, m_aborted = 0, m_halted = 0;
    bit   m_active = 0, m_pop_due = 0, e_load = 0;
    seg_t e_seg = '0;

    task automatic model_reset();
        mq.delete();
        m_running = 0; m_underrun = 0; m_aborted = 0; m_halted = 0;
        m_active = 0; m_pop_due = 0; e_load = 0; e_seg = '0;
    endtask

    task automatic model_step();
        bit empty0, full0, eff, ev, go_next, h0;
        empty0  = (mq.size() == 0);
        full0   = (mq.size() == DEPTH);
        h0      = m_halted;
        eff     = (m_running || start) && !stop && !h0;
        ev      = 0;
        go_next = 0;
        e_load  = 0;
        if (m_pop_due) begin
            if (!abort && mq.size() > 0) begin
                e_seg    = mq.pop_front();
                e_load   = 1;
                m_active = 1;
            end
        end else if (m_active) begin
            if (done && !abort) begin
                m_active = 0;
                if (eff && !empty0) go_next = 1;
                else if (eff) ev = 1;
            end
        end else if (!h0 && eff && !empty0) begin
            go_next = 1;
        end
        m_pop_due = go_next && !abort;
        if (abort) begin
            m_halted = 1;
            m_active = 0;
        end else if (stop) begin
            m_halted = 0;
        end
        if (abort || stop || ev) m_running = 0;
        else if (start && !h0)   m_running = 1;
        if (stop)    m_underrun = 0;
        else if (ev) m_underrun = 1;
        if (abort)     m_aborted = 1;
        else if (stop) m_aborted = 0;
        if (abort || stop) mq.delete();
        else if (wr_stb && !full0) mq.push_back('{dt: wr_dt, steps: wr_steps, a: wr_a, j: wr_j});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("load",            32'(load),            32'(e_load));
        chk("set_dt_limit",    32'(set_dt_limit),    32'(e_load));
        chk("set_steps_limit", 32'(set_steps_limit), 32'(e_load));
        chk("set_a",           32'(set_a),           32'(e_load));
        chk("set_j",           32'(set_j),           32'(e_load));
        chk("reset_dt",        32'(reset_dt),        32'(e_load));
        chk("reset_steps",     32'(reset_steps),     32'(e_load));
        chk("dt_val",          dt_val,               e_seg.dt);
        chk("steps_val",       steps_val,            e_seg.steps);
        chk("a_val",           a_val,                e_seg.a);
        chk("j_val",           j_val,                e_seg.j);
        chk("count",           32'(count),           32'(mq.size()));
        chk("empty",           32'(empty),           32'(mq.size() == 0));
        chk("full",            32'(full),            32'(mq.size() == DEPTH));
        chk("running",         32'(running),         32'(m_running));
        chk("busy",            32'(busy),            32'(m_active || m_pop_due));
        chk("underrun",        32'(underrun),        32'(m_underrun));
        chk("aborted",         32'(aborted),         32'(m_aborted));
    end

    function automatic seg_t mk(input logic [31:0] d, input logic [31:0] s,
                                input logic [31:0] ac, input logic [31:0] jk);
        mk = '{dt: d, steps: s, a: ac, j: jk};
    endfunction

    function automatic bit pct(input int p);
        pct = ($urandom_range(0, 99) < p);
    endfunction

    // Apply one cycle of inputs (sampled at the next rising edge), return at the following falling edge
    task automatic cyc(input bit w, input seg_t s, input bit st, input bit sp, input bit dn, input bit ab);
        wr_stb = w;
        {wr_dt, wr_steps, wr_a, wr_j} = s;
        start = st; stop = sp; done = dn; abort = ab;
        @(negedge clk);
        wr_stb = 0; start = 0; stop = 0; done = 0; abort = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0, 0);
    endtask

    task automatic push(input seg_t s);
        cyc(1, s, 0, 0, 0, 0);
    endtask

    // Latency in cycles from the input cycle just applied to the load pulse (bounded)
    task automatic wait_load(output int lat);
        lat = 1;
        while (!load && lat < 16) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_no_load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("no_load", 32'(load), 32'd0);
        end
    endtask

    initial begin
        int lat;
        rst_n = 0;
        wr_stb = 0; start = 0; stop = 0; done = 0; abort = 0;
        wr_dt = '0; wr_steps = '0; wr_a = '0; wr_j = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        rst_n = 1;
        idle(1);

        // Three segments issued in order, two cycles after start/done each
        push(mk(32'd200, 32'd3, 32'd200, 32'd0));
        push(mk(32'd100, 32'd0, 32'd1000, 32'd0));
        push(mk(32'd50, 32'd0, 32'hFFFF_F448, 32'd0));
        cyc(0, '0, 1, 0, 0, 0);
        wait_load(lat);
        chk("t1_lat0", 32'(lat), 32'd2);
        chk("t1_dt0", dt_val, 32'd200);
        chk("t1_steps0", steps_val, 32'd3);
        chk("t1_a0", a_val, 32'd200);
        idle(3);
        cyc(0, '0, 0, 0, 1, 0);
        wait_load(lat);
        chk("t1_lat1", 32'(lat), 32'd2);
        chk("t1_dt1", dt_val, 32'd100);
        chk("t1_a1", a_val, 32'd1000);
        cyc(0, '0, 0, 0, 1, 0);
        wait_load(lat);
        chk("t1_lat2", 32'(lat), 32'd2);
        chk("t1_dt2", dt_val, 32'd50);
        chk("t1_a2", a_val, 32'hFFFF_F448);
        cyc(0, '0, 0, 0, 1, 0);
        chk("t1_underrun", 32'(underrun), 32'd1);
        chk("t1_running", 32'(running), 32'd0);
        cyc(0, '0, 0, 1, 0, 0);

        // Fill to DEPTH, drop the ninth, drain in order
        for (int i = 0; i < 9; i++) push(mk(32'(1000 + i), 32'(i), 32'(i), 32'(i)));
        idle(1);
        chk("t2_count", 32'(count), 32'd8);
        chk("t2_full", 32'(full), 32'd1);
        cyc(0, '0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            wait_load(lat);
            chk("t2_order", dt_val, 32'(1000 + i));
            cyc(0, '0, 0, 0, 1, 0);
        end
        chk("t2_empty", 32'(empty), 32'd1);
        cyc(0, '0, 0, 1, 0, 0);

        // Abort in RUN with 4 queued; start ignored in HALT; stop returns to IDLE
        for (int i = 0; i < 5; i++) push(mk(32'(10 + i), 32'd1, 32'd2, 32'd3));
        cyc(0, '0, 1, 0, 0, 0);
        wait_load(lat);
        chk("t4_count", 32'(count), 32'd4);
        idle(2);
        cyc(0, '0, 0, 0, 0, 1);
        chk("t4_aborted", 32'(aborted), 32'd1);
        chk("t4_count0", 32'(count), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        expect_no_load(3);
        cyc(0, '0, 1, 0, 0, 0);
        chk("t4_start_ign", 32'(running), 32'd0);
        expect_no_load(3);
        cyc(0, '0, 0, 1, 0, 0);
        chk("t4_stop_clr", 32'(aborted), 32'd0);
        push(mk(32'd77, 32'd0, 32'd0, 32'd0));
        cyc(0, '0, 1, 0, 0, 0);
        wait_load(lat);
        chk("t4_idle_lat", 32'(lat), 32'd2);
        chk("t4_idle_dt", dt_val, 32'd77);
        cyc(0, '0, 0, 1, 0, 0);
        cyc(0, '0, 0, 0, 1, 0);

        // done and abort together: abort wins, nothing issued
        for (int i = 0; i < 3; i++) push(mk(32'(300 + i), 32'd0, 32'd0, 32'd0));
        cyc(0, '0, 1, 0, 0, 0);
        wait_load(lat);
        cyc(0, '0, 0, 0, 1, 1);
        expect_no_load(4);
        chk("t5_aborted", 32'(aborted), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        cyc(0, '0, 0, 1, 0, 0);

        // Asynchronous reset mid-RUN discards the queue
        for (int i = 0; i < 3; i++) push(mk(32'(400 + i), 32'd5, 32'd6, 32'd7));
        cyc(0, '0, 1, 0, 0, 0);
        wait_load(lat);
        #2 rst_n = 0;
        #1;
        chk("t6_load", 32'(load), 32'd0);
        chk("t6_dt", dt_val, 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_running", 32'(running), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1;
        cyc(0, '0, 1, 0, 0, 0);
        expect_no_load(4);
        chk("t6_idle", 32'(busy), 32'd0);
        cyc(0, '0, 0, 1, 0, 0);

        // Randomized traffic; pointers wrap many times
        for (int i = 0; i < 1500; i++) begin
            cyc(pct(55), mk($urandom, $urandom, $urandom, $urandom),
                pct(10), pct(2), pct(30), pct(1));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
